qpsk_mapper: RTL and testbench

- Sits directly downstream of the `interleaver` stage in the 802.11a transmit chain.
- Accepts one 96-bit interleaved OFDM symbol (48 QPSK subcarriers × 2 coded bits) each time the interleaver pulses its `ready`.
- Double-buffers the symbol and streams one signed I/Q constellation point per enabled clock toward the IFFT/pilot-insertion stage.
- Flags overflow if the interleaver outruns it.

---
 rtl/qpsk_mapper.sv | 176 +++++++++++++++++
 tb/tb_qpsk_mapper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_mapper.sv
// qpsk_mapper: double-buffered QPSK mapper between the 802.11a interleaver
// and the IFFT/pilot-insertion stage. Takes one 96-bit symbol per in_valid
// strobe and streams one signed I/Q point per enabled clock.
// Optional feature macro: MAPPER_PILOT_EN (52-point symbols with 4 BPSK pilots).
module qpsk_mapper #(
  parameter int W   = 8,
  parameter int AMP = 91
`ifdef MAPPER_PILOT_EN
  ,
  parameter int PAMP = 127
`endif
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         en,
  input  logic [95:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_i,
  output logic [W-1:0] out_q,
  output logic         out_valid,
  output logic [5:0]   out_idx,
  output logic         out_last,
  output logic         overflow
);

`ifdef MAPPER_PILOT_EN
  localparam int NPTS = 52;
`else
  localparam int NPTS = 48;
`endif
  localparam logic [5:0]   LAST = 6'(NPTS - 1);
  localparam logic [W-1:0] POS  = W'(AMP);
  localparam logic [W-1:0] NEG  = W'(-AMP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [95:0]   active_reg, pending_reg;
  logic          pending_full_reg;
  logic [5:0]    cnt_reg;
  logic          overflow_reg;
  logic [W-1:0]  out_i_reg, out_q_reg;
  logic          out_valid_reg, out_last_reg;
  logic [5:0]    out_idx_reg;

  logic          emit, final_pt;
  logic [5:0]    didx;
  logic [W-1:0]  point_i, point_q;

`ifdef MAPPER_PILOT_EN
  // Data bits are addressed by their own counter so pilot slots skip no bits.
  logic [5:0]    dcnt_reg;
  logic          is_pilot;
  assign is_pilot = (cnt_reg == 6'd5) || (cnt_reg == 6'd19) ||
                    (cnt_reg == 6'd32) || (cnt_reg == 6'd46);
  assign didx     = dcnt_reg;
`else
  assign didx     = cnt_reg;
`endif

  assign in_ready  = !pending_full_reg;
  assign out_i     = out_i_reg;
  assign out_q     = out_q_reg;
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign out_last  = out_last_reg;
  assign overflow  = overflow_reg;

  // Map the current point: bit 1 -> +AMP, bit 0 -> -AMP; pilots override.
  always_comb begin
    point_i = active_reg[{didx, 1'b0}] ? POS : NEG;
    point_q = active_reg[{didx, 1'b1}] ? POS : NEG;
`ifdef MAPPER_PILOT_EN
    if (is_pilot) begin
      point_i = (cnt_reg == 6'd46) ? W'(-PAMP) : W'(PAMP);
      point_q = '0;
    end
`endif
  end

  // Next-state logic and per-cycle emit/final decode.
  always_comb begin
    state_next = state_reg;
    emit       = 1'b0;
    final_pt   = 1'b0;
    case (state_reg)
      IDLE: if (in_valid) state_next = RUN;
      RUN: begin
        if (en) begin
          emit = 1'b1;
          if (cnt_reg == LAST) begin
            final_pt = 1'b1;
            if (!pending_full_reg && !in_valid) state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Buffers, counters and overflow flag; final point hands pending to active.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      active_reg       <= '0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      cnt_reg          <= '0;
      overflow_reg     <= 1'b0;
`ifdef MAPPER_PILOT_EN
      dcnt_reg         <= '0;
`endif
    end else if (state_reg == IDLE) begin
      if (in_valid) begin
        active_reg <= in_data;
        cnt_reg    <= '0;
`ifdef MAPPER_PILOT_EN
        dcnt_reg   <= '0;
`endif
      end
    end else if (final_pt) begin
      cnt_reg <= '0;
`ifdef MAPPER_PILOT_EN
      dcnt_reg <= '0;
`endif
      if (pending_full_reg) begin
        active_reg <= pending_reg;
        if (in_valid) pending_reg      <= in_data;
        else          pending_full_reg <= 1'b0;
      end else if (in_valid) begin
        active_reg <= in_data;
      end
    end else begin
      if (emit) begin
        cnt_reg <= cnt_reg + 6'd1;
`ifdef MAPPER_PILOT_EN
        if (!is_pilot) dcnt_reg <= dcnt_reg + 6'd1;
`endif
      end
      if (in_valid) begin
        if (!pending_full_reg) begin
          pending_reg      <= in_data;
          pending_full_reg <= 1'b1;
        end else begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  // Registered output point; value/index hold while not emitting.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_i_reg     <= '0;
      out_q_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= emit;
      out_last_reg  <= final_pt;
      if (emit) begin
        out_i_reg   <= point_i;
        out_q_reg   <= point_q;
        out_idx_reg <= cnt_reg;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_mapper.sv
// Scoreboard bench for qpsk_mapper: a block-level occupancy model decides
// which blocks are accepted and when points are emitted; accepted blocks are
// expanded into expected points; a negedge monitor compares the DUT stream.
module tb_qpsk_mapper;
  localparam int W    = 8;
  localparam int AMP  = 91;
  localparam int PAMP = 127;
`ifdef MAPPER_PILOT_EN
  localparam int NPTS = 52;
`else
  localparam int NPTS = 48;
`endif

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         en = 1'b0;
  logic [95:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_i, out_q;
  logic         out_valid;
  logic [5:0]   out_idx;
  logic         out_last;
  logic         overflow;

  qpsk_mapper #(
    .W(W),
    .AMP(AMP)
`ifdef MAPPER_PILOT_EN
    ,
    .PAMP(PAMP)
`endif
  ) dut (
    .Clk(Clk), .Rst(Rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_i(out_i), .out_q(out_q), .out_valid(out_valid),
    .out_idx(out_idx), .out_last(out_last), .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int i;
    int q;
    int idx;
    bit last;
  } pt_t;

  pt_t sb[$];
  int  held = 0;       // blocks held by the mapper (active + pending)
  int  rem = 0;        // points left in the active block
  bit  exp_valid = 0;
  bit  exp_ovf = 0;
  bit  mon_on = 0;
  int  checks = 0;
  int  errors = 0;

  function automatic bit is_pilot(input int k);
`ifdef MAPPER_PILOT_EN
    return (k == 5) || (k == 19) || (k == 32) || (k == 46);
`else
    return (k < 0);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expand an accepted block into its expected constellation points.
  task automatic push_block(input logic [95:0] d);
    int b = 0;
    for (int k = 0; k < NPTS; k++) begin
      pt_t p;
      if (is_pilot(k)) begin
        p.i = (k == 46) ? -PAMP : PAMP;
        p.q = 0;
      end else begin
        p.i = d[2*b]   ? AMP : -AMP;
        p.q = d[2*b+1] ? AMP : -AMP;
        b++;
      end
      p.idx  = k;
      p.last = (k == NPTS - 1);
      sb.push_back(p);
    end
  endtask

  // Reference model: occupancy of at most two blocks, drain on enabled cycles.
  always @(posedge Clk) begin
    bit emit, fin, acc;
    if (Rst) begin
      held = 0; rem = 0; exp_valid = 0; exp_ovf = 0;
      sb.delete();
    end else begin
      emit = en && (held > 0);
      fin  = emit && (rem == 1);
      acc  = in_valid && ((held < 2) || fin);
      if (in_valid && !acc) exp_ovf = 1;
      exp_valid = emit;
      if (emit) begin
        rem--;
        if (rem == 0) begin
          held--;
          if (held > 0) rem = NPTS;
        end
      end
      if (acc) begin
        push_block(in_data);
        held++;
        if (held == 1) rem = NPTS;
      end
    end
  end

  // Monitor: compare stream timing, flags, and popped points.
  always @(negedge Clk) begin
    if (mon_on && !Rst) begin
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("in_ready", int'(in_ready), int'(held < 2));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_point", 1, 0);
        end else begin
          pt_t p;
          p = sb.pop_front();
          chk("out_i", int'($signed(out_i)), p.i);
          chk("out_q", int'($signed(out_q)), p.q);
          chk("out_idx", int'(out_idx), p.idx);
          chk("out_last", int'(out_last), int'(p.last));
          $display("point idx=%0d i=%0d q=%0d last=%0d", out_idx,
                   $signed(out_i), $signed(out_q), out_last);
        end
      end else begin
        chk("out_last_idle", int'(out_last), 0);
      end
    end
  end

  task automatic reset_checks();
    chk("rst_out_i", int'(out_i), 0);
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    mon_on = 0; Rst = 1; in_valid = 0; en = 0;
    repeat (3) @(negedge Clk);
    reset_checks();
    Rst = 0; mon_on = 1;
  endtask

  task automatic cyc(input bit v, input logic [95:0] d, input bit e);
    @(negedge Clk);
    in_valid = v; in_data = d; en = e;
    if (v) $display("block in: data=%h en=%0d", d, e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b1);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [95:0] alt;
    alt = {24{4'h5}};
    Rst = 1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    reset_checks();
    Rst = 0; mon_on = 1;

    // single all-zero block
    cyc(1'b1, '0, 1'b1); idle(NPTS + 8);
    // bit mapping
    cyc(1'b1, alt, 1'b1); idle(NPTS + 8);
    cyc(1'b1, 96'h1, 1'b1); idle(NPTS + 8);
    // two blocks 48 cycles apart, contiguous
    cyc(1'b1, rnd96(), 1'b1); idle(47);
    cyc(1'b1, rnd96(), 1'b1); idle(2 * NPTS + 10);
    // enable stall mid-block
    cyc(1'b1, rnd96(), 1'b1); idle(20);
    repeat (5) cyc(1'b0, '0, 1'b0);
    idle(NPTS);
    // overflow: three consecutive strobes
    repeat (3) cyc(1'b1, rnd96(), 1'b1);
    idle(3 * NPTS);
    chk("overflow_sticky", int'(overflow), 1);
    do_reset();
    // randomized traffic
    for (int n = 0; n < 1500; n++)
      cyc($urandom_range(0, 39) == 0, rnd96(), $urandom_range(0, 9) != 0);
    idle(3 * NPTS);
    chk("drained", sb.size(), 0);
    // reset mid-symbol
    cyc(1'b1, rnd96(), 1'b1); idle(10);
    do_reset();
    idle(5);
    chk("sb_empty_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
